// File: rtl/noc_pkg.sv
// Shared NoC types and constants: flit layout, arbiter FSM states and the default flit width.
package noc_pkg;

  localparam int FLIT_W   = 16;
  localparam int HEAD_BIT = 15;
  localparam int TAIL_BIT = 14;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/noc_rr_arb.sv
// Combinational round-robin picker: the first set req bit at or after ptr (wrapping) wins.
module noc_rr_arb #(
  parameter int NUM_IN = 5,
  parameter int IDX_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_IN-1:0] gnt,
  output logic [IDX_W-1:0]  idx,
  output logic              any
);

  always_comb begin
    int j;
    logic [IDX_W-1:0] jj;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    jj  = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_IN) j = j - NUM_IN;
      jj = IDX_W'(j);
      if (!any && req[jj]) begin
        any     = 1'b1;
        gnt[jj] = 1'b1;
        idx     = jj;
      end
    end
  end

endmodule

// File: rtl/noc_out_arbiter.sv
// NoC output-port arbiter: round-robin pop of input queues, credit flow control, registered link.
// Define NOC_ARB_WORMHOLE_EN to lock the port to one input from a head flit through its tail flit.
module noc_out_arbiter #(
  parameter int NUM_IN  = 5,
  parameter int CREDITS = 4,
  parameter int FLIT_W  = noc_pkg::FLIT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN-1:0]        req_i,
  input  logic [NUM_IN*FLIT_W-1:0] data_i,
  output logic [NUM_IN-1:0]        pop_o,
  output logic [FLIT_W-1:0]        data_o,
  output logic                     valid_o,
  input  logic                     credit_i
);
  import noc_pkg::*;

  localparam int IDX_W = $clog2(NUM_IN);
  localparam int CW    = $clog2(CREDITS + 1);

  arb_state_e        state;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  owner;
  logic [CW-1:0]     credits;

  logic [NUM_IN-1:0] lock_mask;
  logic [NUM_IN-1:0] elig;
  logic [NUM_IN-1:0] gnt;
  logic [IDX_W-1:0]  win;
  logic              grant;
  logic [FLIT_W-1:0] win_flit;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (int'(i) == NUM_IN - 1) ? '0 : i + 1'b1;
  endfunction

  // While locked only the owner may contend; credits gate everybody.
  assign lock_mask = (state == LOCKED) ? (NUM_IN'(1) << owner) : '1;
  assign elig      = (rst || credits == '0) ? '0 : (req_i & lock_mask);

  noc_rr_arb #(
    .NUM_IN (NUM_IN),
    .IDX_W  (IDX_W)
  ) u_rr_arb (
    .req (elig),
    .ptr (ptr),
    .gnt (gnt),
    .idx (win),
    .any (grant)
  );

  assign pop_o    = gnt;
  assign win_flit = data_i[int'(win)*FLIT_W +: FLIT_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      owner   <= '0;
      credits <= CW'(CREDITS);
      data_o  <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= grant;
      if (grant) data_o <= win_flit;

      if (grant && !credit_i) begin
        credits <= credits - 1'b1;
      end else if (!grant && credit_i && credits != CW'(CREDITS)) begin
        credits <= credits + 1'b1;
      end

`ifdef NOC_ARB_WORMHOLE_EN
      case (state)
        IDLE: begin
          if (grant) begin
            // A stray body flit with no head is forwarded as if it were a single-flit packet.
            if (win_flit[HEAD_BIT] && !win_flit[TAIL_BIT]) begin
              state <= LOCKED;
              owner <= win;
            end else begin
              ptr <= next_idx(win);
            end
          end
        end
        LOCKED: begin
          if (grant && win_flit[TAIL_BIT]) begin
            state <= IDLE;
            ptr   <= next_idx(owner);
          end
        end
        default: state <= IDLE;
      endcase
`else
      if (grant) ptr <= next_idx(win);
`endif
    end
  end

endmodule

// File: tb/tb_noc_out_arbiter.sv
// Randomised scoreboard bench for noc_out_arbiter; the bench plays the input queues and models arbitration.
module tb_noc_out_arbiter;
  localparam int NUM_IN  = 5;
  localparam int CREDITS = 4;
  localparam int FW      = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_IN-1:0]    req_i = '0;
  logic [NUM_IN*FW-1:0] data_i = '0;
  logic [NUM_IN-1:0]    pop_o;
  logic [FW-1:0]        data_o;
  logic                 valid_o;
  logic                 credit_i = 1'b0;

  noc_out_arbiter #(.NUM_IN(NUM_IN), .CREDITS(CREDITS), .FLIT_W(FW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req_i),
    .data_i   (data_i),
    .pop_o    (pop_o),
    .data_o   (data_o),
    .valid_o  (valid_o),
    .credit_i (credit_i)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int vcount = 0;

  logic [FW-1:0] q [NUM_IN][$];
  logic [FW-1:0] sb [$];
  int            wins [$];
  bit            rec_wins = 1'b0;

  // Reference state: credits available downstream, round-robin start, packet lock.
  int m_cred  = CREDITS;
  int m_ptr   = 0;
  int m_owner = 0;
  bit m_lock  = 1'b0;

`ifdef NOC_ARB_WORMHOLE_EN
  localparam bit WORM = 1'b1;
`else
  localparam bit WORM = 1'b0;
`endif

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (valid_o) begin
      vcount++;
      if (sb.size() == 0) begin
        chk(1'b0, "unexpected_flit", 32'(data_o), 32'hFFFF_FFFF);
      end else begin
        logic [FW-1:0] e;
        e = sb.pop_front();
        chk(data_o === e, "data_o", 32'(data_o), 32'(e));
      end
    end
  end

  task automatic push_pkt(input int i, input int len);
    logic [13:0] p;
    for (int k = 0; k < len; k++) begin
      p = 14'($urandom);
      if (len == 1)          q[i].push_back({2'b11, p});
      else if (k == 0)       q[i].push_back({2'b10, p});
      else if (k == len - 1) q[i].push_back({2'b01, p});
      else                   q[i].push_back({2'b00, p});
    end
  endtask

  task automatic step(input logic cred, input logic [NUM_IN-1:0] stall, input bit do_rst);
    int w;
    logic [NUM_IN-1:0] exp_pop;
    logic [FW-1:0] f;
    @(negedge clk);
    rst      = do_rst;
    credit_i = do_rst ? 1'b0 : cred;
    for (int i = 0; i < NUM_IN; i++) begin
      req_i[i] = !do_rst && q[i].size() > 0 && !stall[i];
      data_i[i*FW +: FW] = (q[i].size() > 0) ? q[i][0] : FW'($urandom);
    end
    #1;
    w = -1;
    if (!do_rst && m_cred > 0) begin
      for (int k = 0; k < NUM_IN; k++) begin
        int j;
        j = (m_ptr + k) % NUM_IN;
        if (w < 0 && req_i[j] && (!m_lock || j == m_owner)) w = j;
      end
    end
    exp_pop = (w >= 0) ? (NUM_IN'(1) << w) : '0;
    chk(pop_o === exp_pop, "pop_o", 32'(pop_o), 32'(exp_pop));
    if (do_rst) begin
      m_cred = CREDITS; m_ptr = 0; m_owner = 0; m_lock = 1'b0;
    end else begin
      if (w >= 0) begin
        f = q[w].pop_front();
        sb.push_back(f);
        if (rec_wins) wins.push_back(w);
        if (!WORM) begin
          m_ptr = (w + 1) % NUM_IN;
        end else if (!m_lock) begin
          if (f[15] && !f[14]) begin m_lock = 1'b1; m_owner = w; end
          else m_ptr = (w + 1) % NUM_IN;
        end else if (f[14]) begin
          m_lock = 1'b0; m_ptr = (m_owner + 1) % NUM_IN;
        end
      end
      if (w >= 0 && !cred) m_cred--;
      else if (w < 0 && cred && m_cred < CREDITS) m_cred++;
    end
  endtask

  task automatic reset_all();
    for (int i = 0; i < NUM_IN; i++) q[i].delete();
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
  endtask

  initial begin
    int v0;
    reset_all();
    @(posedge clk); #1;
    chk(valid_o === 1'b0, "reset_valid", 32'(valid_o), 32'd0);
    chk(data_o === '0, "reset_data", 32'(data_o), 32'd0);

    // Single flit from input 0.
    q[0].push_back(16'hC0AA);
    step(1'b0, '0, 1'b0);
    @(posedge clk); #1;
    chk(valid_o === 1'b1, "first_valid", 32'(valid_o), 32'd1);
    chk(data_o === 16'hC0AA, "first_data", 32'(data_o), 32'hC0AA);

    // All inputs busy with single flits, credit every cycle: strict rotation.
    reset_all();
    for (int i = 0; i < NUM_IN; i++) for (int k = 0; k < 3; k++) push_pkt(i, 1);
    wins.delete(); rec_wins = 1'b1;
    for (int c = 0; c < 6; c++) step(1'b1, '0, 1'b0);
    rec_wins = 1'b0;
    chk(wins.size() == 6, "rr_count", 32'(wins.size()), 32'd6);
    for (int c = 0; c < 6 && c < wins.size(); c++)
      chk(wins[c] == c % NUM_IN, "rr_order", 32'(wins[c]), 32'(c % NUM_IN));

    // Credit exhaustion, then a single returned credit.
    reset_all();
    for (int k = 0; k < 8; k++) begin push_pkt(0, 1); push_pkt(1, 1); end
    v0 = vcount;
    for (int c = 0; c < 8; c++) step(1'b0, '0, 1'b0);
    chk(vcount - v0 == CREDITS, "credit_limit", 32'(vcount - v0), 32'(CREDITS));
    step(1'b1, '0, 1'b0);
    v0 = vcount;
    for (int c = 0; c < 4; c++) step(1'b0, '0, 1'b0);
    chk(vcount - v0 == 1, "one_credit_one_flit", 32'(vcount - v0), 32'd1);

    // Packet on input 2 against constant requests on input 3.
    reset_all();
    q[2].push_back(16'h8001); q[2].push_back(16'h0002); q[2].push_back(16'h4003);
    for (int k = 0; k < 4; k++) push_pkt(3, 1);
    wins.delete(); rec_wins = 1'b1;
    for (int c = 0; c < 4; c++) step(1'b1, '0, 1'b0);
    rec_wins = 1'b0;
    if (wins.size() == 4) begin
      if (WORM) begin
        chk(wins[1] == 2 && wins[2] == 2 && wins[3] == 3, "wormhole_lock", 32'(wins[1]*100 + wins[2]*10 + wins[3]), 32'd223);
      end else begin
        chk(wins[1] == 3 && wins[2] == 2 && wins[3] == 3, "interleave", 32'(wins[1]*100 + wins[2]*10 + wins[3]), 32'd323);
      end
    end else begin
      chk(1'b0, "pkt_grant_count", 32'(wins.size()), 32'd4);
    end

    // Reset while locked on a packet: everything restarts from input 0.
    reset_all();
    push_pkt(1, 3);
    step(1'b1, '0, 1'b0);
    for (int i = 0; i < NUM_IN; i++) q[i].delete();
    step(1'b0, '0, 1'b1);
    @(posedge clk); #1;
    chk(valid_o === 1'b0, "rst_mid_pkt_valid", 32'(valid_o), 32'd0);
    push_pkt(1, 1); push_pkt(0, 1);
    for (int c = 0; c < 3; c++) step(1'b0, '0, 1'b0);
    for (int k = 0; k < 6; k++) push_pkt(2, 1);
    v0 = vcount;
    for (int c = 0; c < 8; c++) step(1'b0, '0, 1'b0);
    chk(vcount - v0 == CREDITS - 2, "rst_credits", 32'(vcount - v0), 32'(CREDITS - 2));

    // Random traffic.
    reset_all();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) push_pkt($urandom_range(0, NUM_IN - 1), $urandom_range(1, 4));
      step(1'($urandom_range(0, 2) != 0),
           ($urandom_range(0, 3) == 0) ? NUM_IN'($urandom) : '0, 1'b0);
    end
    for (int c = 0; c < 200; c++) step(1'b1, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    @(posedge clk); #2;
    chk(sb.size() == 0, "sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
